// File: rtl/spi_burst_master.sv
// SPI burst master: header + up to MAX_BYTES data words per chip-select,
// SCLK generated from spi_clk by CLK_DIV, all four CPOL/CPHA modes.
// Every bit is driven at its start and sampled at its mid-point; the SCLK
// level of each half is what separates the four modes.
module spi_burst_master #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BYTES = 4,
  parameter int LEN_W     = 2,
  parameter int CLK_DIV   = 2,
  parameter int CPOL      = 1,
  parameter int CPHA      = 1,
  parameter int HDR_FLAGS = 1
) (
  input  logic                          spi_clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          rw,
  input  logic [LEN_W-1:0]              len,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [MAX_BYTES*DATA_W-1:0]   wdata,
  output logic                          busy,
  output logic                          done,
  output logic [MAX_BYTES*DATA_W-1:0]   rdata,
  output logic                          SPI_CSN,
  output logic                          SPI_CLK,
  output logic                          SPI_SDI,
  input  logic                          SPI_SDO
);
  localparam int DW   = MAX_BYTES * DATA_W;
  localparam int NMAX = ADDR_W + DW;
  localparam int BW   = $clog2(NMAX + 1);
  localparam int CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int WW   = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int PW   = (DW > 1) ? $clog2(DW) : 1;
  localparam logic SCLK_IDLE = 1'(CPOL);
  // SCLK level during the leading half of a bit: CPHA=1 toggles at bit start.
  localparam logic SCLK_LEAD = 1'(CPOL ^ CPHA);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_BYTES - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE, S_GAP} state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic              trail_q;
  logic [BW-1:0]     bit_q, nlast_q;
  logic [NMAX-1:0]   tx_q;
  logic              rd_q;
  logic [WW-1:0]     word_q;
  logic [IW-1:0]     inw_q;
  logic              busy_q, done_q, csn_q, sclk_q, sdi_q;
  logic [DW-1:0]     rdata_q;

  logic [LEN_W-1:0]  len_c;
  logic [ADDR_W-1:0] hdr_c;
  logic [NMAX-1:0]   tx_d;
  logic [BW-1:0]     nlast_d;
  logic [PW-1:0]     rpos_c;
  logic              cnt_last;

  // Out-of-range lengths collapse to the largest burst.
  if ((1 << LEN_W) > MAX_BYTES) begin : g_clamp
    assign len_c = (len > LEN_MAX) ? LEN_MAX : len;
  end else begin : g_noclamp
    assign len_c = len;
  end

  // The two address MSBs are replaced by the flags when HDR_FLAGS is set.
  logic unused_addr_msbs;
  assign unused_addr_msbs = ^addr[ADDR_W-1 -: 2];

  // Frame image captured on accept: header then word 0..N, MSB first; reads send ones.
  always_comb begin
    hdr_c = addr;
    if (HDR_FLAGS != 0) hdr_c = {rw, (len != '0), addr[ADDR_W-3:0]};
    tx_d = '0;
    tx_d[NMAX-1 -: ADDR_W] = hdr_c;
    for (int k = 0; k < MAX_BYTES; k++)
      tx_d[(MAX_BYTES-1-k)*DATA_W +: DATA_W] = rw ? {DATA_W{1'b1}} : wdata[k*DATA_W +: DATA_W];
    nlast_d = BW'(ADDR_W + DATA_W - 1) + BW'(len_c) * BW'(DATA_W);
  end

  assign rpos_c   = PW'(word_q) * PW'(DATA_W) + PW'(inw_q);
  assign cnt_last = (cnt_q == CW'(CLK_DIV - 1));

  // Transfer sequencer with registered pin and handshake outputs.
  always_ff @(posedge spi_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      trail_q <= 1'b0;
      bit_q   <= '0;
      nlast_q <= '0;
      tx_q    <= '0;
      rd_q    <= 1'b0;
      word_q  <= '0;
      inw_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      csn_q   <= 1'b1;
      sclk_q  <= SCLK_IDLE;
      sdi_q   <= 1'b1;
      rdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          state_q <= S_SETUP;
          busy_q  <= 1'b1;
          csn_q   <= 1'b0;
          sclk_q  <= SCLK_IDLE;
          sdi_q   <= (CPHA == 0) ? tx_d[NMAX-1] : 1'b1;
          tx_q    <= tx_d;
          nlast_q <= nlast_d;
          rd_q    <= rw;
          rdata_q <= '0;
          cnt_q   <= '0;
          trail_q <= 1'b0;
          bit_q   <= '0;
          word_q  <= '0;
          inw_q   <= IW'(DATA_W - 1);
        end
        S_SETUP: begin
          if (cnt_last) begin
            state_q <= S_SHIFT;
            cnt_q   <= '0;
            sclk_q  <= SCLK_LEAD;
            sdi_q   <= tx_q[NMAX-1];
          end else cnt_q <= cnt_q + 1'b1;
        end
        S_SHIFT: begin
          if (!cnt_last) cnt_q <= cnt_q + 1'b1;
          else begin
            cnt_q <= '0;
            if (!trail_q) begin
              // Mid-bit: the sampling edge in every mode.
              trail_q <= 1'b1;
              sclk_q  <= ~sclk_q;
              if (rd_q && bit_q >= BW'(ADDR_W)) rdata_q[rpos_c] <= SPI_SDO;
            end else begin
              trail_q <= 1'b0;
              if (bit_q >= BW'(ADDR_W)) begin
                if (inw_q == '0) begin
                  inw_q  <= IW'(DATA_W - 1);
                  word_q <= word_q + 1'b1;
                end else inw_q <= inw_q - 1'b1;
              end
              if (bit_q == nlast_q) begin
                state_q <= S_HOLD;
                sclk_q  <= SCLK_IDLE;
                sdi_q   <= 1'b1;
              end else begin
                bit_q  <= bit_q + 1'b1;
                tx_q   <= {tx_q[NMAX-2:0], 1'b1};
                sdi_q  <= tx_q[NMAX-2];
                sclk_q <= SCLK_LEAD;
              end
            end
          end
        end
        S_HOLD: begin
          if (cnt_last) begin
            state_q <= S_DONE;
            cnt_q   <= '0;
            csn_q   <= 1'b1;
            done_q  <= 1'b1;
          end else cnt_q <= cnt_q + 1'b1;
        end
        S_DONE: state_q <= S_GAP;
        S_GAP: begin
          if (cnt_last) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else cnt_q <= cnt_q + 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign SPI_CSN = csn_q;
  assign SPI_CLK = sclk_q;
  assign SPI_SDI = sdi_q;
endmodule
